// File: rtl/milestone_sequencer_pkg.sv
// milestone_sequencer_pkg
//   Shared definitions for the image decompressor top-level sequencer and
//   the decode stages it schedules.
//   - Sequencer_state_type : sequencer FSM states
//   - *_BASE_ADDRESS       : SRAM base addresses of the Y/U/V planes and the RGB output
//   - sat_inc32            : 32-bit increment that holds at all-ones instead of wrapping
package milestone_sequencer_pkg;

    typedef enum logic [2:0] {
        S_SEQ_IDLE,
        S_SEQ_LAUNCH,
        S_SEQ_RUN,
        S_SEQ_DRAIN,
        S_SEQ_DONE,
        S_SEQ_ERROR
    } Sequencer_state_type;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;

    localparam logic [SRAM_ADDR_W-1:0] Y_BASE_ADDRESS   = 18'd0;
    localparam logic [SRAM_ADDR_W-1:0] U_BASE_ADDRESS   = 18'd38400;
    localparam logic [SRAM_ADDR_W-1:0] V_BASE_ADDRESS   = 18'd57600;
    localparam logic [SRAM_ADDR_W-1:0] RGB_BASE_ADDRESS = 18'd146944;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/milestone_sequencer_sram_port_mux.sv
// sram_port_mux
//   Combinational selector that connects one stage's SRAM bus to the single
//   external SRAM port. With no grant the port is parked: no write, address
//   and data held at zero.
// Ports:
//   grant            in   1               a stage currently owns the port
//   index            in   2               index of the owning stage
//   stage_address    in   NUM_STAGES*18   stage i at [18i+17:18i]
//   stage_write_data in   NUM_STAGES*16   stage i at [16i+15:16i]
//   stage_we_n       in   NUM_STAGES      active-low write enables
//   address          out  18              selected address
//   write_data       out  16              selected write data
//   we_n             out  1               selected write enable, active-low
module sram_port_mux
    import milestone_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic                               grant,
    input  logic [1:0]                         index,
    input  logic [NUM_STAGES*SRAM_ADDR_W-1:0]  stage_address,
    input  logic [NUM_STAGES*SRAM_DATA_W-1:0]  stage_write_data,
    input  logic [NUM_STAGES-1:0]              stage_we_n,
    output logic [SRAM_ADDR_W-1:0]             address,
    output logic [SRAM_DATA_W-1:0]             write_data,
    output logic                               we_n
);

    always_comb begin
        address    = '0;
        write_data = '0;
        we_n       = 1'b1;
        if (grant) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (index == 2'(i)) begin
                    address    = stage_address[SRAM_ADDR_W*i +: SRAM_ADDR_W];
                    write_data = stage_write_data[SRAM_DATA_W*i +: SRAM_DATA_W];
                    we_n       = stage_we_n[i];
                end
            end
        end
    end

endmodule

// File: rtl/milestone_sequencer.sv
// milestone_sequencer
//   Top-level scheduler of the image decompressor. Launches the decode stages
//   one after another (start/done handshake), grants the external SRAM port
//   to the running stage, inserts idle drain cycles between stages, and
//   raises a sticky error on a bad start index or a stage watchdog timeout.
// Optional build macro:
//   SEQ_PERF_COUNT_EN  adds Stage_cycles, the RUN cycle count (done cycle
//                      included) of the most recently completed stage.
// Ports:
//   Clock                  in   1               system clock
//   Reset                  in   1               asynchronous, active-high
//   Start                  in   1               run launch pulse
//   Start_stage            in   2               first stage to run
//   Stage_enable           out  NUM_STAGES      one-hot launch pulse
//   Stage_done             in   NUM_STAGES      per-stage completion pulse
//   Stage_SRAM_address     in   NUM_STAGES*18   flattened stage addresses
//   Stage_SRAM_write_data  in   NUM_STAGES*16   flattened stage write data
//   Stage_SRAM_we_n        in   NUM_STAGES      stage write enables, active-low
//   SRAM_address           out  18              muxed SRAM address
//   SRAM_write_data        out  16              muxed SRAM write data
//   SRAM_we_n              out  1               muxed SRAM write enable
//   Active_stage           out  2               granted stage, valid while Busy
//   Busy                   out  1               run in progress
//   Done                   out  1               run completed pulse
//   Error                  out  1               sticky error flag
//   Stage_cycles           out  32              (SEQ_PERF_COUNT_EN only)
module milestone_sequencer
    import milestone_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_000_000,
    parameter int unsigned DRAIN_CYCLES   = 2
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Start,
    input  logic [1:0]                         Start_stage,
    output logic [NUM_STAGES-1:0]              Stage_enable,
    input  logic [NUM_STAGES-1:0]              Stage_done,
    input  logic [NUM_STAGES*SRAM_ADDR_W-1:0]  Stage_SRAM_address,
    input  logic [NUM_STAGES*SRAM_DATA_W-1:0]  Stage_SRAM_write_data,
    input  logic [NUM_STAGES-1:0]              Stage_SRAM_we_n,
    output logic [SRAM_ADDR_W-1:0]             SRAM_address,
    output logic [SRAM_DATA_W-1:0]             SRAM_write_data,
    output logic                               SRAM_we_n,
    output logic [1:0]                         Active_stage,
    output logic                               Busy,
    output logic                               Done,
    output logic                               Error
`ifdef SEQ_PERF_COUNT_EN
    ,
    output logic [31:0]                        Stage_cycles
`endif
);

    Sequencer_state_type     state, state_next;
    logic [1:0]              active, active_next;
    logic                    busy, busy_next;
    logic                    error, error_next;
    logic                    done, done_next;
    logic [NUM_STAGES-1:0]   enable, enable_next;
    logic [31:0]             watchdog, watchdog_next;
    logic [31:0]             drain_cnt, drain_next;
    logic                    active_done;
    logic                    grant;
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0]             cycles, cycles_next;
`endif

    // Only the granted stage's done bit is ever looked at.
    always_comb begin
        active_done = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (active == 2'(i)) begin
                active_done = Stage_done[i];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_SEQ_IDLE;
            active    <= '0;
            busy      <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
            enable    <= '0;
            watchdog  <= '0;
            drain_cnt <= '0;
`ifdef SEQ_PERF_COUNT_EN
            cycles    <= '0;
`endif
        end else begin
            state     <= state_next;
            active    <= active_next;
            busy      <= busy_next;
            error     <= error_next;
            done      <= done_next;
            enable    <= enable_next;
            watchdog  <= watchdog_next;
            drain_cnt <= drain_next;
`ifdef SEQ_PERF_COUNT_EN
            cycles    <= cycles_next;
`endif
        end
    end

    always_comb begin
        state_next    = state;
        active_next   = active;
        busy_next     = busy;
        error_next    = error;
        watchdog_next = watchdog;
        drain_next    = drain_cnt;
        enable_next   = '0;
        done_next     = 1'b0;
`ifdef SEQ_PERF_COUNT_EN
        cycles_next   = cycles;
`endif

        unique case (state)
            S_SEQ_IDLE: begin
                if (Start) begin
                    if (32'(Start_stage) < NUM_STAGES) begin
                        active_next = Start_stage;
                        busy_next   = 1'b1;
                        error_next  = 1'b0;
                        state_next  = S_SEQ_LAUNCH;
                    end else begin
                        error_next  = 1'b1;
                    end
                end
            end

            S_SEQ_LAUNCH: begin
                watchdog_next = '0;
                state_next    = S_SEQ_RUN;
            end

            S_SEQ_RUN: begin
                watchdog_next = sat_inc32(watchdog);
                // Done is tested first so a done on the last allowed cycle wins.
                if (active_done) begin
                    drain_next = '0;
                    state_next = S_SEQ_DRAIN;
`ifdef SEQ_PERF_COUNT_EN
                    cycles_next = sat_inc32(watchdog);
`endif
                end else if (watchdog >= TIMEOUT_CYCLES - 32'd1) begin
                    state_next = S_SEQ_ERROR;
                end
            end

            S_SEQ_DRAIN: begin
                if (drain_cnt + 32'd1 >= DRAIN_CYCLES) begin
                    if (32'(active) == NUM_STAGES - 1) begin
                        state_next = S_SEQ_DONE;
                    end else begin
                        active_next = active + 2'd1;
                        state_next  = S_SEQ_LAUNCH;
                    end
                end else begin
                    drain_next = drain_cnt + 32'd1;
                end
            end

            S_SEQ_DONE: begin
                busy_next  = 1'b0;
                state_next = S_SEQ_IDLE;
            end

            S_SEQ_ERROR: begin
                error_next = 1'b1;
                busy_next  = 1'b0;
                state_next = S_SEQ_IDLE;
            end

            default: begin
                state_next = S_SEQ_IDLE;
            end
        endcase

        // Enable and Done are registered from the next state so they are
        // glitch-free and coincide exactly with the LAUNCH/DONE cycles.
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            enable_next[i] = (state_next == S_SEQ_LAUNCH) && (active_next == 2'(i));
        end
        done_next = (state_next == S_SEQ_DONE);
    end

    assign grant = (state == S_SEQ_RUN);

    sram_port_mux #(
        .NUM_STAGES (NUM_STAGES)
    ) u_sram_port_mux (
        .grant            (grant),
        .index            (active),
        .stage_address    (Stage_SRAM_address),
        .stage_write_data (Stage_SRAM_write_data),
        .stage_we_n       (Stage_SRAM_we_n),
        .address          (SRAM_address),
        .write_data       (SRAM_write_data),
        .we_n             (SRAM_we_n)
    );

    assign Stage_enable = enable;
    assign Active_stage = active;
    assign Busy         = busy;
    assign Done         = done;
    assign Error        = error;
`ifdef SEQ_PERF_COUNT_EN
    assign Stage_cycles = cycles;
`endif

endmodule

// File: tb/tb_milestone_sequencer.sv
// tb_milestone_sequencer
//   Randomized bench for milestone_sequencer. For each run the expected
//   cycle-by-cycle timeline (launch, run, drain, done/error phases) is worked
//   out arithmetically from the chosen stage durations, then the run is
//   played against the DUT with random bus traffic, spurious Start pulses and
//   stray done pulses from non-active stages.
module tb_milestone_sequencer;
    import milestone_sequencer_pkg::*;

    localparam int NS  = 3;
    localparam int T   = 50;
    localparam int DR  = 2;
    localparam int MAXC = 600;

    logic                 Clock;
    logic                 Reset;
    logic                 Start;
    logic [1:0]           Start_stage;
    logic [NS-1:0]        Stage_enable;
    logic [NS-1:0]        Stage_done;
    logic [NS*18-1:0]     Stage_SRAM_address;
    logic [NS*16-1:0]     Stage_SRAM_write_data;
    logic [NS-1:0]        Stage_SRAM_we_n;
    logic [17:0]          SRAM_address;
    logic [15:0]          SRAM_write_data;
    logic                 SRAM_we_n;
    logic [1:0]           Active_stage;
    logic                 Busy;
    logic                 Done;
    logic                 Error;
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0]          Stage_cycles;
`endif

    milestone_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (32'd50),
        .DRAIN_CYCLES   (DR)
    ) dut (
        .Clock                 (Clock),
        .Reset                 (Reset),
        .Start                 (Start),
        .Start_stage           (Start_stage),
        .Stage_enable          (Stage_enable),
        .Stage_done            (Stage_done),
        .Stage_SRAM_address    (Stage_SRAM_address),
        .Stage_SRAM_write_data (Stage_SRAM_write_data),
        .Stage_SRAM_we_n       (Stage_SRAM_we_n),
        .SRAM_address          (SRAM_address),
        .SRAM_write_data       (SRAM_write_data),
        .SRAM_we_n             (SRAM_we_n),
        .Active_stage          (Active_stage),
        .Busy                  (Busy),
        .Done                  (Done),
        .Error                 (Error)
`ifdef SEQ_PERF_COUNT_EN
        ,
        .Stage_cycles          (Stage_cycles)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Model state carried between runs.
    int  m_act;
    bit  m_err;
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] m_perf;
    logic [31:0] e_perf [MAXC];
`endif

    // Expected timeline of one run: -1 means "none".
    int e_en    [MAXC];
    int e_grant [MAXC];
    int e_act   [MAXC];
    int e_drv   [MAXC];
    bit e_busy  [MAXC];
    bit e_dn    [MAXC];
    bit e_err   [MAXC];
    bit e_launch[MAXC];
    int c_len;

    logic [17:0] addr_drv [NS];
    logic [15:0] data_drv [NS];
    logic        we_drv   [NS];

    task automatic emit(input int en, input bit busy, input bit dn, input int grant,
                        input int act, input int drv, input bit launch, input bit err);
        e_en[c_len]     = en;
        e_busy[c_len]   = busy;
        e_dn[c_len]     = dn;
        e_grant[c_len]  = grant;
        e_act[c_len]    = act;
        e_drv[c_len]    = drv;
        e_launch[c_len] = launch;
        e_err[c_len]    = err;
`ifdef SEQ_PERF_COUNT_EN
        e_perf[c_len]   = m_perf;
`endif
        c_len++;
    endtask

    // Phase lengths: launch 1, run d (or T on timeout), drain DR, then done or error.
    task automatic build_timeline(input int s, input int dur[NS]);
        bit timed_out;
        int last;
        timed_out = 1'b0;
        last      = s;
        c_len     = 0;
        for (int k = s; k < NS; k++) begin
            last = k;
            emit(k, 1, 0, -1, k, -1, 1, 0);
            if (dur[k] <= T) begin
                for (int j = 1; j <= dur[k]; j++)
                    emit(-1, 1, 0, k, k, (j == dur[k]) ? k : -1, 0, 0);
`ifdef SEQ_PERF_COUNT_EN
                m_perf = 32'(dur[k]);
`endif
                for (int j = 0; j < DR; j++)
                    emit(-1, 1, 0, -1, k, -1, 0, 0);
            end else begin
                for (int j = 1; j <= T; j++)
                    emit(-1, 1, 0, k, k, -1, 0, 0);
                emit(-1, 1, 0, -1, k, -1, 0, 0);
                timed_out = 1'b1;
                break;
            end
        end
        if (!timed_out)
            emit(-1, 1, 1, -1, NS - 1, -1, 0, 0);
        emit(-1, 0, 0, -1, last, -1, 0, timed_out);
        emit(-1, 0, 0, -1, last, -1, 0, timed_out);
    endtask

    task automatic drive_buses();
        for (int i = 0; i < NS; i++) begin
            addr_drv[i] = 18'($urandom);
            data_drv[i] = 16'($urandom);
            we_drv[i]   = 1'($urandom);
            Stage_SRAM_address[18*i +: 18]    = addr_drv[i];
            Stage_SRAM_write_data[16*i +: 16] = data_drv[i];
            Stage_SRAM_we_n[i]                = we_drv[i];
        end
    endtask

    task automatic check_outputs(input int en, input bit busy, input bit dn, input bit err,
                                 input int grant, input int act, input bit chk_act);
        logic [NS-1:0] en_exp;
        en_exp = '0;
        if (en >= 0) en_exp[en] = 1'b1;
        check_eq("stage_enable", 64'(Stage_enable), 64'(en_exp));
        check_eq("busy", 64'(Busy), 64'(busy));
        check_eq("done", 64'(Done), 64'(dn));
        check_eq("error", 64'(Error), 64'(err));
        if (chk_act) check_eq("active_stage", 64'(Active_stage), 64'(act));
        if (grant >= 0) begin
            check_eq("sram_address", 64'(SRAM_address), 64'(addr_drv[grant]));
            check_eq("sram_write_data", 64'(SRAM_write_data), 64'(data_drv[grant]));
            check_eq("sram_we_n", 64'(SRAM_we_n), 64'(we_drv[grant]));
        end else begin
            check_eq("sram_address_idle", 64'(SRAM_address), 64'd0);
            check_eq("sram_write_data_idle", 64'(SRAM_write_data), 64'd0);
            check_eq("sram_we_n_idle", 64'(SRAM_we_n), 64'd1);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_sram_we_n", 64'(SRAM_we_n), 64'd1);
        check_eq("rst_sram_address", 64'(SRAM_address), 64'd0);
        check_eq("rst_sram_write_data", 64'(SRAM_write_data), 64'd0);
        check_eq("rst_stage_enable", 64'(Stage_enable), 64'd0);
        check_eq("rst_active_stage", 64'(Active_stage), 64'd0);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        check_eq("rst_error", 64'(Error), 64'd0);
`ifdef SEQ_PERF_COUNT_EN
        check_eq("rst_stage_cycles", 64'(Stage_cycles), 64'd0);
`endif
    endtask

    task automatic run_seq(input int s, input int d0, input int d1, input int d2, input int abort_at);
        int dur[NS];
        logic [NS-1:0] dv;
        dur = '{d0, d1, d2};
        if (s < NS) build_timeline(s, dur);

        @(posedge Clock); #1;
        Start       = 1'b1;
        Start_stage = 2'(s);
        Stage_done  = '0;
        drive_buses();
        @(negedge Clock);
        check_outputs(-1, 0, 0, m_err, -1, m_act, 0);

        if (s >= NS) begin
            @(posedge Clock); #1;
            Start = 1'b0;
            drive_buses();
            @(negedge Clock);
            check_outputs(-1, 0, 0, 1, -1, m_act, 0);
            m_err = 1'b1;
            return;
        end

        for (int n = 0; n < c_len; n++) begin
            @(posedge Clock); #1;
            Start       = e_busy[n] && ($urandom_range(0, 3) == 0);
            Start_stage = 2'($urandom_range(0, 3));
            dv = '0;
            if (e_drv[n] >= 0) dv[e_drv[n]] = 1'b1;
            for (int i = 0; i < NS; i++)
                if (i != e_act[n] && $urandom_range(0, 5) == 0) dv[i] = 1'b1;
            if (e_launch[n] && $urandom_range(0, 2) == 0) dv[e_act[n]] = 1'b1;
            Stage_done = dv;
            drive_buses();
            if (n == abort_at && e_grant[n] >= 0) begin
                addr_drv[e_grant[n]] = U_BASE_ADDRESS;
                data_drv[e_grant[n]] = 16'hA5A5;
                we_drv[e_grant[n]]   = 1'b0;
                Stage_SRAM_address[18*e_grant[n] +: 18]    = U_BASE_ADDRESS;
                Stage_SRAM_write_data[16*e_grant[n] +: 16] = 16'hA5A5;
                Stage_SRAM_we_n[e_grant[n]]                = 1'b0;
            end
            @(negedge Clock);
            check_outputs(e_en[n], e_busy[n], e_dn[n], e_err[n], e_grant[n], e_act[n], e_busy[n]);
`ifdef SEQ_PERF_COUNT_EN
            check_eq("stage_cycles", 64'(Stage_cycles), 64'(e_perf[n]));
`endif
            if (n == abort_at) begin
                #2 Reset = 1'b1;
                #1 check_reset_values();
                Start      = 1'b0;
                Stage_done = '0;
                @(posedge Clock); #1;
                Reset = 1'b0;
                m_err = 1'b0;
                m_act = 0;
`ifdef SEQ_PERF_COUNT_EN
                m_perf = '0;
`endif
                return;
            end
        end
        m_act = e_act[c_len-1];
        m_err = e_err[c_len-1];
    endtask

    function automatic int rand_dur();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return T;
        if (r == 1) return T + 1;
        return $urandom_range(1, 12);
    endfunction

    initial begin
        Reset                 = 1'b0;
        Start                 = 1'b0;
        Start_stage           = '0;
        Stage_done            = '0;
        Stage_SRAM_address    = '0;
        Stage_SRAM_write_data = '0;
        Stage_SRAM_we_n       = '1;
        m_err = 1'b0;
        m_act = 0;
`ifdef SEQ_PERF_COUNT_EN
        m_perf = '0;
`endif
        for (int i = 0; i < NS; i++) begin
            addr_drv[i] = '0;
            data_drv[i] = '0;
            we_drv[i]   = 1'b1;
        end

        #2 Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_reset_values();
        Reset = 1'b0;

        run_seq(0, 10, 10, 10, -1);
        run_seq(0, 100, 5, 5, -1);
        run_seq(1, 7, 4, 6, -1);
        run_seq(3, 5, 5, 5, -1);
        run_seq(2, 1, 1, T, -1);
        run_seq(0, 1, 1, T + 1, -1);
        for (int r = 0; r < 20; r++)
            run_seq($urandom_range(0, 3), rand_dur(), rand_dur(), rand_dur(), -1);
        run_seq(0, 3, 20, 5, 9);
        run_seq(0, 4, 4, 4, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, required $finish before 2ms");
        $fatal(1);
    end

endmodule

// File: doc/milestone_sequencer.md
Name: milestone_sequencer

Overview:
- Top-level scheduler for the image decompressor.
- Runs the decode stages (M1 colourspace/upsampling, M2, M3) one after another, each with a start/done handshake.
- Grants the single external SRAM port to exactly one stage at a time through a mux driven by a registered grant.
- Sits between the stage blocks and the SRAM controller, and reports progress, completion and watchdog errors.

Parameters:
- NUM_STAGES, 3: number of sequenced stages. Index 0 runs first.
- TIMEOUT_CYCLES, 32'd4_000_000: maximum cycles a stage may stay active before an error is raised.
- DRAIN_CYCLES, 2: idle SRAM cycles inserted after each stage's done, to flush pending reads and writes.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse that launches a run
- Start_stage  in  2  index of the first stage to run
- Stage_enable  out  NUM_STAGES  one-hot, one-cycle pulse to the stage being launched
- Stage_done  in  NUM_STAGES  one-cycle completion pulse from each stage
- Stage_SRAM_address  in  NUM_STAGES*18  flattened address bus per stage; stage i occupies bits [18i+17:18i]
- Stage_SRAM_write_data  in  NUM_STAGES*16  flattened write data per stage
- Stage_SRAM_we_n  in  NUM_STAGES  active-low write enable per stage
- SRAM_address  out  18  muxed address to the SRAM controller
- SRAM_write_data  out  16  muxed write data
- SRAM_we_n  out  1  muxed write enable, active-low
- Active_stage  out  2  index of the granted stage; valid while Busy
- Busy  out  1  high from Start acceptance until DONE or ERROR
- Done  out  1  one-cycle pulse when the last stage has drained
- Error  out  1  sticky error flag; cleared only by an accepted Start or by Reset

Behaviour:
- Reset values: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, Stage_enable=0, Active_stage=0, Busy=0, Done=0, Error=0, state S_SEQ_IDLE.
- Reset acts immediately at any point; a stage in progress is abandoned with no SRAM write issued.
- SRAM mux:
  - Combinational from the registered grant.
  - When granted: SRAM outputs equal stage[Active_stage]'s buses, with zero added latency.
  - When not granted: we_n=1, address=0, data=0.
  - Grant is asserted only in S_SEQ_RUN.
- S_SEQ_IDLE:
  - On Start with Start_stage<NUM_STAGES: Active_stage<=Start_stage, Busy<=1, Error<=0, go to S_SEQ_LAUNCH.
  - On Start with Start_stage>=NUM_STAGES: Error<=1, remain in IDLE.
- S_SEQ_LAUNCH: Stage_enable[Active_stage]<=1 for exactly one cycle; clear the watchdog counter; go to S_SEQ_RUN.
- S_SEQ_RUN:
  - Grant is active and the watchdog increments every cycle.
  - On Stage_done[Active_stage]: go to S_SEQ_DRAIN with drain counter=0. The grant drops on the next cycle, so the done cycle itself is still granted.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without done: go to S_SEQ_ERROR.
- S_SEQ_DRAIN:
  - No grant for DRAIN_CYCLES cycles.
  - Then, if Active_stage==NUM_STAGES-1, go to S_SEQ_DONE; otherwise Active_stage+1 and go to S_SEQ_LAUNCH.
- S_SEQ_DONE: Done=1 for one cycle, Busy<=0, go to S_SEQ_IDLE.
- S_SEQ_ERROR: Error<=1, Busy<=0, no grant, go to S_SEQ_IDLE. Error persists.
- Boundary cases:
  - Start while Busy is ignored.
  - Stage_done bits from non-active stages are ignored in every state.
  - Done and timeout in the same cycle: done wins.
  - Start in the same cycle as the DONE pulse is ignored, because the block is not yet in IDLE.
  - A stage's done pulse arriving during its own LAUNCH cycle is ignored; stages must take at least one cycle.
- Watchdog is 32-bit and saturates; it never wraps.

Optional Feature:
- Macro: SEQ_PERF_COUNT_EN.
- With the macro defined:
  - Extra output Stage_cycles (32 bits): number of RUN cycles of the most recently completed stage, counted from the first RUN cycle through the done cycle inclusive.
  - Updated on entry to DRAIN; reset value 0.
- Without it: the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Add Sequencer_state_type (S_SEQ_IDLE, S_SEQ_LAUNCH, S_SEQ_RUN, S_SEQ_DRAIN, S_SEQ_DONE, S_SEQ_ERROR) to define_state.h, alongside the existing milestone state enums.
- Put the SRAM base-address constants shared by the stages (Y=0, U=38400, V=57600, RGB=146944) in the same header.
- One sub-module: sram_port_mux. Purely combinational; inputs are the grant valid flag, the index and the flattened buses.

Test Plan:
- Full run: Start with Start_stage=0; each stage model pulses done after 10 cycles.
  - Stage_enable pulses 001, then 010, then 100.
  - Each enable is separated by 10 RUN cycles plus 2 DRAIN cycles plus 1 LAUNCH cycle.
  - Done pulses once, then Busy=0 and Error=0.
- Mux: stage 1 drives address 18'd38400, data 16'hA5A5, we_n=0 while granted.
  - SRAM outputs match in the same cycle.
  - In DRAIN: we_n=1 and address=0.
  - Stage 0's bus values never appear at the SRAM outputs.
- Timeout: TIMEOUT_CYCLES=50, stage 0 never asserts done.
  - Error=1 after 50 RUN cycles; Busy=0; grant dropped.
  - A following Start clears Error.
- Robustness: Start pulsed while Busy; Stage_done[2] pulsed while stage 0 is active.
  - Both are ignored; the sequence proceeds unchanged.
- Bad start: Start_stage=3 with NUM_STAGES=3 gives Error=1, Busy stays 0, and no Stage_enable pulse.
- Reset mid-run: assert Reset during stage 1's RUN with we_n=0.
  - SRAM_we_n=1 in the same cycle and all outputs return to their reset values.
  - With SEQ_PERF_COUNT_EN defined, Stage_cycles=0.
